operand_a_sequencer: RTL and testbench

Multicycle controller that sequences the ALU operand-A source mux and its producers. It accepts one operand-fetch command at a time and fetches operand A either from the register file or from the wait-stated memory port. It drives the mux select (`muxAControl`: 0 = memory data, 1 = register read data) and the operand-A register load strobe. It sits between the main control unit and the operand-A datapath.

---
 rtl/operand_a_sequencer.sv | 147 ++++++++++++++
 tb/tb_operand_a_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_a_sequencer.sv
// operand_a_sequencer: multicycle controller for the ALU operand-A path.
// Fetches operand A from the register file or the wait-stated memory port,
// then drives the mux select and the operand-A load strobe.
// Optional feature: define OPA_TIMEOUT_EN to add the memory-wait counter and
// the ERROR state. Without it, MEM waits indefinitely and err is tied to 0.
module operand_a_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic op_mem,
    input  logic mem_ack,
    output logic reg_rd_en,
    output logic mem_req,
    output logic muxAControl,
    output logic a_load,
    output logic busy,
    output logic done,
    output logic err
);

    // Reject an illegal timeout at elaboration time.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("operand_a_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef OPA_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REG   = 3'd1,
        MEM   = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    // Counter value seen in the last permitted MEM cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REG   = 3'd1,
        MEM   = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;
`endif

    state_t state;

    // State register with Moore outputs registered alongside the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            reg_rd_en   <= 1'b0;
            mem_req     <= 1'b0;
            muxAControl <= 1'b0;
            a_load      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef OPA_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            // Single-cycle strobes default low; busy and the mux select hold.
            reg_rd_en <= 1'b0;
            mem_req   <= 1'b0;
            a_load    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op_mem) begin
                            state       <= MEM;
                            mem_req     <= 1'b1;
                            muxAControl <= 1'b0;
`ifdef OPA_TIMEOUT_EN
                            wait_cnt    <= '0;
`endif
                        end else begin
                            state       <= REG;
                            reg_rd_en   <= 1'b1;
                            muxAControl <= 1'b1;
                        end
                    end
                end
                REG: begin
                    state  <= LOAD;
                    a_load <= 1'b1;
                end
                MEM: begin
`ifdef OPA_TIMEOUT_EN
                    // Saturating count of MEM cycles spent so far.
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    // An ack in the last permitted cycle still wins over the timeout.
                    if (mem_ack) begin
                        state  <= LOAD;
                        a_load <= 1'b1;
                    end else if (wait_cnt >= CNT_LAST) begin
                        state <= ERROR;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        mem_req <= 1'b1;
                    end
`else
                    if (mem_ack) begin
                        state  <= LOAD;
                        a_load <= 1'b1;
                    end else begin
                        mem_req <= 1'b1;
                    end
`endif
                end
                LOAD: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef OPA_TIMEOUT_EN
                ERROR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_a_sequencer.sv
// Self-checking bench for operand_a_sequencer: table-driven per-cycle vectors
// plus hand-written memory-wait, timeout and reset-abort sequences.
module tb_operand_a_sequencer;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic op_mem = 1'b0;
    logic mem_ack = 1'b0;
    logic reg_rd_en, mem_req, muxAControl, a_load, busy, done, err;

    int total = 0;
    int passed = 0;

    operand_a_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .op_mem(op_mem),
        .mem_ack(mem_ack),
        .reg_rd_en(reg_rd_en),
        .mem_req(mem_req),
        .muxAControl(muxAControl),
        .a_load(a_load),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Output order: {reg_rd_en, mem_req, muxAControl, a_load, busy, done, err}
    typedef struct {
        logic       st;
        logic       op;
        logic       ack;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [6:0] outs();
        return {reg_rd_en, mem_req, muxAControl, a_load, busy, done, err};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a memory command; ack is presented during MEM cycle ack_at (0 = never).
    task automatic run_mem(input int ack_at, output int nreq, output int done_at,
                           output logic err_seen, output logic ld_seen);
        nreq = 0;
        done_at = -1;
        err_seen = 1'b0;
        ld_seen = 1'b0;
        start = 1'b1;
        op_mem = 1'b1;
        mem_ack = 1'b0;
        tick();
        start = 1'b0;
        op_mem = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (mem_req) nreq++;
            if (a_load) ld_seen = 1'b1;
            if (err) err_seen = 1'b1;
            if (done) begin
                done_at = c;
                break;
            end
            mem_ack = (c == ack_at);
            tick();
        end
        mem_ack = 1'b0;
        tick();
    endtask

    int   nreq, done_at;
    logic err_seen, ld_seen, any_done, any_busy;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 7'b1010100};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'b0011100};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'b0010110};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 7'b0010000};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 7'b0100100};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 7'b0001100};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 7'b0000110};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 7'b0000000};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 7'b0100100};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 7'b0100100};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 7'b0100100};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 7'b0001100};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 7'b0000110};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 7'b0000000};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 7'b1010100};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 7'b0011100};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 7'b0010110};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 7'b0010000};

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1));
            op_mem = 1'($urandom_range(0, 1));
            mem_ack = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("reset_outs_%0d", i), 32'(outs()), 32'd0);
        end
        start = 1'b0;
        op_mem = 1'b0;
        mem_ack = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_after_reset", 32'(outs()), 32'd0);

        // Per-cycle vectors: register path, zero-wait memory, busy ignore, back-to-back
        for (int i = 0; i < 18; i++) begin
            start = vecs[i].st;
            op_mem = vecs[i].op;
            mem_ack = vecs[i].ack;
            tick();
            check($sformatf("vec_%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        start = 1'b0;
        op_mem = 1'b0;
        mem_ack = 1'b0;

        // Memory, zero wait via sequence task
        run_mem(1, nreq, done_at, err_seen, ld_seen);
        check("mem0_req_cycles", 32'(nreq), 32'd1);
        check("mem0_done_cycle", 32'(done_at), 32'd3);

        // Memory, 5 wait cycles
        run_mem(6, nreq, done_at, err_seen, ld_seen);
        check("mem5_req_cycles", 32'(nreq), 32'd6);
        check("mem5_done_cycle", 32'(done_at), 32'd8);
        check("mem5_err", 32'(err_seen), 32'd0);
        check("mem5_load", 32'(ld_seen), 32'd1);

`ifdef OPA_TIMEOUT_EN
        // Timeout with no ack
        run_mem(0, nreq, done_at, err_seen, ld_seen);
        check("to_req_cycles", 32'(nreq), 32'(TO));
        check("to_done_cycle", 32'(done_at), 32'(TO + 1));
        check("to_err", 32'(err_seen), 32'd1);
        check("to_load", 32'(ld_seen), 32'd0);
        check("to_idle_after", 32'(busy), 32'd0);

        // Ack in the last permitted cycle wins over the timeout
        run_mem(TO, nreq, done_at, err_seen, ld_seen);
        check("lastack_req_cycles", 32'(nreq), 32'(TO));
        check("lastack_done_cycle", 32'(done_at), 32'(TO + 2));
        check("lastack_err", 32'(err_seen), 32'd0);
        check("lastack_load", 32'(ld_seen), 32'd1);
`else
        // Ack withheld for 100 cycles: no timeout, done 2 cycles after ack
        run_mem(101, nreq, done_at, err_seen, ld_seen);
        check("longwait_req_cycles", 32'(nreq), 32'd101);
        check("longwait_done_cycle", 32'(done_at), 32'd103);
        check("longwait_err", 32'(err_seen), 32'd0);
        check("longwait_load", 32'(ld_seen), 32'd1);
`endif

        // Reset abort during MEM
        start = 1'b1;
        op_mem = 1'b1;
        tick();
        start = 1'b0;
        op_mem = 1'b0;
        check("abort_in_mem", 32'(mem_req), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_outs_zero", 32'(outs()), 32'd0);
        tick();
        reset_n = 1'b1;
        mem_ack = 1'b1;
        any_done = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) any_done = 1'b1;
            if (busy) any_busy = 1'b1;
        end
        mem_ack = 1'b0;
        check("abort_no_done", 32'(any_done), 32'd0);
        check("abort_stays_idle", 32'(any_busy), 32'd0);

        // Register path still works after the abort
        start = 1'b1;
        op_mem = 1'b0;
        tick();
        start = 1'b0;
        check("post_abort_reg", 32'(outs()), 32'(7'b1010100));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
